// File: rtl/aes_seq_if.sv
// Control/data bundle between the AES mode sequencer (master) and its host and datapath blocks (slave).
// No storage; width follows DATA_W.
interface aes_seq_if #(
    parameter int DATA_W = 128
);
    logic [1:0]        SW;
    logic              start;
    logic [DATA_W-1:0] plaintext;
    logic [1:0]        key_sel;
    logic [3:0]        num_rounds;
    logic              kex_start;
    logic              kex_done;
    logic              enc_start;
    logic              enc_done;
    logic [DATA_W-1:0] enc_data;
    logic              dec_start;
    logic              dec_done;
    logic [DATA_W-1:0] dec_data;
    logic [DATA_W-1:0] cipher_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic              err;
    logic [7:0]        disp_byte;

    modport master (
        input  SW, start, plaintext, kex_done, enc_done, enc_data, dec_done, dec_data,
        output key_sel, num_rounds, kex_start, enc_start, dec_start,
               cipher_out, busy, done, pass, err, disp_byte
    );

    modport slave (
        output SW, start, plaintext, kex_done, enc_done, enc_data, dec_done, dec_data,
        input  key_sel, num_rounds, kex_start, enc_start, dec_start,
               cipher_out, busy, done, pass, err, disp_byte
    );
endinterface

// File: rtl/aes_mode_sequencer.sv
// Runs key expansion, encrypt, decrypt in turn; done rises 7 cycles after start with 1-cycle responders.
// start ignored while busy; each phase waits for its done pulse (bounded only with AES_SEQ_TIMEOUT_EN).
module aes_mode_sequencer #(
    parameter int DATA_W         = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic      clk,
    input  logic      rst,
    aes_seq_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_KEX, S_ENC, S_DEC, S_FIN} state_t;

    state_t            state_q, state_n;
    logic [DATA_W-1:0] pt_q;
    logic              accept, kex_adv, enc_adv, dec_adv, timeout_hit;
    logic              kex_start_n, enc_start_n, dec_start_n, done_n;

    function automatic logic [1:0] map_sel(input logic [1:0] sw);
        return (sw == 2'd3) ? 2'd0 : sw;
    endfunction

    function automatic logic [3:0] rounds_for(input logic [1:0] sel);
        case (sel)
            2'd1:    return 4'd12;
            2'd2:    return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    // A done pulse counts only in its own phase and never alongside its own start strobe.
    assign accept  = (state_q == S_IDLE) && bus.start;
    assign kex_adv = (state_q == S_KEX) && bus.kex_done && !bus.kex_start;
    assign enc_adv = (state_q == S_ENC) && bus.enc_done && !bus.enc_start;
    assign dec_adv = (state_q == S_DEC) && bus.dec_done && !bus.dec_start;

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] phase_cnt;
    logic             in_phase;

    assign in_phase    = (state_q == S_KEX) || (state_q == S_ENC) || (state_q == S_DEC);
    assign timeout_hit = in_phase && !(kex_adv || enc_adv || dec_adv) &&
                         (phase_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_cnt <= '0;
        end else if (state_n != state_q) begin
            phase_cnt <= '0;
        end else if (in_phase) begin
            phase_cnt <= phase_cnt + CNT_W'(1);
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_n     = state_q;
        kex_start_n = 1'b0;
        enc_start_n = 1'b0;
        dec_start_n = 1'b0;
        done_n      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_n     = S_KEX;
                    kex_start_n = 1'b1;
                end
            end
            S_KEX: begin
                if (kex_adv) begin
                    state_n     = S_ENC;
                    enc_start_n = 1'b1;
                end else if (timeout_hit) begin
                    state_n = S_IDLE;
                end
            end
            S_ENC: begin
                if (enc_adv) begin
                    state_n     = S_DEC;
                    dec_start_n = 1'b1;
                end else if (timeout_hit) begin
                    state_n = S_IDLE;
                end
            end
            S_DEC: begin
                if (dec_adv) begin
                    state_n = S_FIN;
                end else if (timeout_hit) begin
                    state_n = S_IDLE;
                end
            end
            S_FIN: begin
                state_n = S_IDLE;
                done_n  = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            pt_q           <= '0;
            bus.key_sel    <= 2'd0;
            bus.num_rounds <= 4'd10;
            bus.kex_start  <= 1'b0;
            bus.enc_start  <= 1'b0;
            bus.dec_start  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.pass       <= 1'b0;
            bus.err        <= 1'b0;
            bus.cipher_out <= '0;
        end else begin
            state_q       <= state_n;
            bus.kex_start <= kex_start_n;
            bus.enc_start <= enc_start_n;
            bus.dec_start <= dec_start_n;
            bus.busy      <= (state_n != S_IDLE);
            bus.done      <= done_n;
            if (accept) begin
                bus.key_sel    <= map_sel(bus.SW);
                bus.num_rounds <= rounds_for(map_sel(bus.SW));
                pt_q           <= bus.plaintext;
                bus.pass       <= 1'b0;
                bus.err        <= 1'b0;
            end
            if (enc_adv) begin
                bus.cipher_out <= bus.enc_data;
            end
            if (dec_adv) begin
                bus.pass <= (bus.dec_data == pt_q);
            end
            if (timeout_hit) begin
                bus.err  <= 1'b1;
                bus.pass <= 1'b0;
            end
        end
    end

    assign bus.disp_byte = bus.cipher_out[7:0];
endmodule

// File: tb/tb_aes_mode_sequencer.sv
// Randomised bench for aes_mode_sequencer: responders with random latency, bus noise while busy,
// expectations from sequence-level rules (latency = sum of responder delays + 4).
module tb_aes_mode_sequencer;
    localparam int TO = 16;

    logic clk;
    logic rst;
    int   err_cnt;
    int   chk_cnt;
    logic [127:0] model_cipher;

    aes_seq_if #(.DATA_W(128)) bus ();

    aes_mode_sequencer #(.DATA_W(128), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_reset_values(input string tag);
        check_val({tag, "_busy"},  128'(bus.busy), 128'(0));
        check_val({tag, "_done"},  128'(bus.done), 128'(0));
        check_val({tag, "_pass"},  128'(bus.pass), 128'(0));
        check_val({tag, "_err"},   128'(bus.err), 128'(0));
        check_val({tag, "_ksel"},  128'(bus.key_sel), 128'(0));
        check_val({tag, "_nrnd"},  128'(bus.num_rounds), 128'(10));
        check_val({tag, "_ciph"},  bus.cipher_out, 128'(0));
        check_val({tag, "_disp"},  128'(bus.disp_byte), 128'(0));
        check_val({tag, "_strb"},  128'({bus.kex_start, bus.enc_start, bus.dec_start}), 128'(0));
    endtask

    // mode 0: normal sequence, 1: reset asserted once DEC starts, 2: cipher never answers
    task automatic run_seq(input logic [1:0] sw, input logic [127:0] pt, input logic [127:0] encd,
                           input logic [127:0] decd, input int dk, input int de, input int dd,
                           input bit noise, input int mode);
        int   n_kex, n_enc, n_dec, n_done, done_e, fall_e, tk, te, td;
        bit   kex_fired, finished, aborted;
        logic [1:0] exp_ks;
        n_kex = 0; n_enc = 0; n_dec = 0; n_done = 0;
        done_e = -1; fall_e = -1; tk = 0; te = 0; td = 0;
        kex_fired = 1'b0; finished = 1'b0; aborted = 1'b0;
        exp_ks = (sw == 2'd3) ? 2'd0 : sw;

        @(negedge clk);
        bus.SW = sw;
        bus.plaintext = pt;
        bus.start = 1'b1;
        for (int e = 0; e < 400; e++) begin
            @(negedge clk);
            if (bus.kex_start) n_kex++;
            if (bus.enc_start) n_enc++;
            if (bus.dec_start) n_dec++;
            if (bus.done) begin
                n_done++;
                if (done_e < 0) done_e = e;
            end
            if (!bus.busy && fall_e < 0) fall_e = e;
            if (mode == 1 && n_dec > 0) begin aborted = 1'b1; break; end
            if (mode == 2 && fall_e >= 0 && e >= fall_e + 3) begin finished = 1'b1; break; end
            if (mode == 0 && done_e >= 0 && e >= done_e + 2) begin finished = 1'b1; break; end

            bus.start    = 1'b0;
            bus.kex_done = 1'b0;
            bus.enc_done = 1'b0;
            bus.dec_done = 1'b0;
            bus.enc_data = rand128();
            bus.dec_data = rand128();
            if (tk > 0) begin
                tk--;
                if (tk == 0) begin bus.kex_done = 1'b1; kex_fired = 1'b1; end
            end
            if (te > 0) begin
                te--;
                if (te == 0) begin bus.enc_done = 1'b1; bus.enc_data = encd; end
            end
            if (td > 0) begin
                td--;
                if (td == 0) begin bus.dec_done = 1'b1; bus.dec_data = decd; end
            end
            if (bus.kex_start) tk = dk;
            if (bus.enc_start && mode != 2) te = de;
            if (bus.dec_start) td = dd;
            if (noise && bus.busy) begin
                bus.start     = 1'($urandom_range(0, 1));
                bus.SW        = 2'($urandom_range(0, 3));
                bus.plaintext = rand128();
                if (n_dec == 0 && $urandom_range(0, 2) == 0) bus.dec_done = 1'b1;
                if (n_enc == 0 && $urandom_range(0, 2) == 0) bus.enc_done = 1'b1;
                if (kex_fired && !bus.kex_done && $urandom_range(0, 2) == 0) bus.kex_done = 1'b1;
            end
        end
        bus.start    = 1'b0;
        bus.kex_done = 1'b0;
        bus.enc_done = 1'b0;
        bus.dec_done = 1'b0;

        if (mode == 1) begin
            check_val("abort_reached", 128'(aborted), 128'(1));
            #2 rst = 1'b1;
            #1;
            check_reset_values("midrst");
            @(negedge clk);
            rst = 1'b0;
            model_cipher = '0;
        end else begin
            check_val("seq_complete", 128'(finished), 128'(1));
            check_val("key_sel",    128'(bus.key_sel), 128'(exp_ks));
            check_val("num_rounds", 128'(bus.num_rounds), 128'(10 + 2 * int'(exp_ks)));
            check_val("n_kex_start", 128'(n_kex), 128'(1));
            check_val("n_enc_start", 128'(n_enc), 128'(1));
            check_val("busy_end",    128'(bus.busy), 128'(0));
            if (mode == 0) begin
                model_cipher = encd;
                check_val("cipher_out",  bus.cipher_out, encd);
                check_val("disp_byte",   128'(bus.disp_byte), 128'(encd[7:0]));
                check_val("pass",        128'(bus.pass), 128'(decd == pt));
                check_val("err",         128'(bus.err), 128'(0));
                check_val("n_done",      128'(n_done), 128'(1));
                check_val("done_latency", 128'(done_e), 128'(dk + de + dd + 4));
                check_val("n_dec_start", 128'(n_dec), 128'(1));
            end else begin
                check_val("to_err",      128'(bus.err), 128'(1));
                check_val("to_pass",     128'(bus.pass), 128'(0));
                check_val("to_n_done",   128'(n_done), 128'(0));
                check_val("to_n_dec",    128'(n_dec), 128'(0));
                check_val("to_busy_fall", 128'(fall_e), 128'(dk + 1 + TO));
                check_val("to_cipher",   bus.cipher_out, model_cipher);
            end
        end
    endtask

    initial begin
        logic [127:0] pt, encd, decd;
        err_cnt = 0;
        chk_cnt = 0;
        model_cipher = '0;
        rst = 1'b1;
        bus.SW = 2'd0; bus.start = 1'b0; bus.plaintext = '0;
        bus.kex_done = 1'b0; bus.enc_done = 1'b0; bus.dec_done = 1'b0;
        bus.enc_data = '0; bus.dec_data = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        pt = 128'h00112233445566778899aabbccddeeff;
        run_seq(2'd0, pt, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, pt, 1, 1, 1, 1'b0, 0);

        // outputs hold in IDLE while the switches move
        repeat (4) begin
            @(negedge clk);
            bus.SW = 2'($urandom_range(0, 3));
        end
        check_val("hold_cipher", bus.cipher_out, model_cipher);
        check_val("hold_ksel",   128'(bus.key_sel), 128'(0));

        for (int s = 1; s < 4; s++) begin
            pt = rand128();
            run_seq(2'(s), pt, rand128(), pt, 1, 1, 1, 1'b0, 0);
        end

        pt = rand128();
        run_seq(2'd2, pt, rand128(), pt ^ 128'd1, 1, 1, 1, 1'b0, 0);

        for (int i = 0; i < 10; i++) begin
            pt   = rand128();
            encd = rand128();
            decd = ($urandom_range(0, 1) == 1) ? pt : (pt ^ (128'd1 << $urandom_range(0, 127)));
            run_seq(2'($urandom_range(0, 3)), pt, encd, decd,
                    int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                    1'b1, 0);
        end

        pt = rand128();
        run_seq(2'd1, pt, rand128(), pt, 2, 1, 3, 1'b0, 1);
        pt = rand128();
        run_seq(2'd2, pt, rand128(), pt, 1, 1, 1, 1'b0, 0);

`ifdef AES_SEQ_TIMEOUT_EN
        pt = rand128();
        run_seq(2'd1, pt, rand128(), pt, 1, 1, 1, 1'b0, 2);
        pt = rand128();
        run_seq(2'd0, pt, rand128(), pt, 1, 2, 1, 1'b0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
